// File: rtl/et_pkg.sv
// Shared types and helpers for the early-terminating stochastic number generator.
package et_pkg;

  typedef enum logic [1:0] {
    ET_IDLE = 2'd0,
    ET_RUN  = 2'd1,
    ET_DONE = 2'd2
  } et_state_e;

  function automatic int clamp_k(input int k_init, input int w);
    return (k_init > w) ? w : k_init;
  endfunction

  // Reverses the low k bits of value; bits at and above k come back as zero.
  function automatic logic [31:0] bitrev_k(input logic [31:0] value, input int k);
    logic [31:0] rev;
    rev = 32'd0;
    for (int b = 0; b < 32; b++) begin
      if (b < k) begin
        rev = rev | (((value >> b) & 32'd1) << (k - 1 - b));
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/et_rng.sv
// Combinational van der Corput source: maps counter c and precision k to one
// W-bit threshold per stream, optionally XOR-scrambled per stream.
module et_rng
  import et_pkg::*;
#(
  parameter int W    = 6,
  parameter int N    = 2,
  parameter int CORR = 0
) (
  input  logic [W:0]          c,
  input  logic [W-1:0]        k,
  output logic [N-1:0][W-1:0] r
);

  logic [W:0] mask;

  always_comb begin
    mask = (W+1)'((1 << k) - 1);
    r    = '0;
    // XOR with a constant below 2^k keeps each stream a permutation of 0..L-1.
    for (int i = 0; i < N; i++) begin
      r[i] = W'(bitrev_k(32'(((CORR != 0) ? c : (c ^ (W+1)'(i))) & mask), int'(k))
                << (W - int'(k)));
    end
  end

endmodule

// File: rtl/et_sng.sv
// Early-terminating stochastic number generator: emits N bitstreams of length 2^k.
// Optional per-stream ones counters are built when ET_ONES_CNT_EN is defined.
module et_sng
  import et_pkg::*;
#(
  parameter int W        = 6,
  parameter int N        = 2,
  parameter int CORR     = 0,
  parameter int S_GROUPS = (CORR != 0) ? 1 : N
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N-1:0][W-1:0]         Bxs,
  input  logic [S_GROUPS-1:0][W-1:0]  S,
  input  logic [W-1:0]                k_init,
  output logic                        busy,
  output logic [N-1:0]                bits,
  output logic                        bit_valid,
  output logic                        done
`ifdef ET_ONES_CNT_EN
  ,
  output logic [N-1:0][W:0]           ones_cnt
`endif
);

  et_state_e           state_q, state_d;
  logic [N-1:0][W-1:0] bx_q, bx_d;
  logic [W-1:0]        k_q, k_d;
  logic [W:0]          c_q, c_d;
  logic                busy_q, busy_d;
  logic [N-1:0]        bits_q, bits_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [W:0]          last_c;
  logic                accept;
  logic [N-1:0][W-1:0] r;

  et_rng #(.W(W), .N(N), .CORR(CORR)) u_rng (
    .c (c_q),
    .k (k_q),
    .r (r)
  );

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    k_d     = k_q;
    c_d     = c_q;
    bits_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    last_c  = ((W+1)'(1) << k_q) - (W+1)'(1);
    case (state_q)
      ET_IDLE: begin
        if (start) begin
          accept = 1'b1;
          for (int i = 0; i < N; i++) begin
            bx_d[i] = Bxs[i] & S[(CORR != 0) ? 0 : i];
          end
          k_d     = W'(clamp_k(int'(k_init), W));
          c_d     = '0;
          state_d = ET_RUN;
        end else begin
          state_d = ET_IDLE;
        end
      end
      ET_RUN: begin
        valid_d = 1'b1;
        for (int i = 0; i < N; i++) begin
          bits_d[i] = (bx_q[i] > r[i]);
        end
        if (c_q == last_c) begin
          state_d = ET_DONE;
        end else begin
          c_d = c_q + (W+1)'(1);
        end
      end
      ET_DONE: begin
        done_d  = 1'b1;
        state_d = ET_IDLE;
      end
      default: begin
        state_d = ET_IDLE;
      end
    endcase
    // Busy covers the accept cycle through the cycle the last bit is visible.
    busy_d = (state_q == ET_RUN) || (state_d == ET_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ET_IDLE;
      bx_q    <= '0;
      k_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      k_q     <= k_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign bits      = bits_q;
  assign bit_valid = valid_q;
  assign done      = done_q;

`ifdef ET_ONES_CNT_EN
  logic [N-1:0][W:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (accept) begin
      ones_d = '0;
    end else if (valid_d) begin
      for (int i = 0; i < N; i++) begin
        ones_d[i] = ones_q[i] + (W+1)'(bits_d[i]);
      end
    end else begin
      ones_d = ones_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_cnt = ones_q;
`endif

endmodule
